// File: rtl/conv_loop_sequencer.sv
// rtl/conv_loop_sequencer.sv - loop-nest sequencer for the binary (XNOR) conv datapath
// Walks oco/j/i/wj/wi/ico/oci for a runtime layer shape and drives load, exec and flush handshakes.
module conv_loop_sequencer #(
  parameter int TPO    = 8,
  parameter int WORD_W = 32,
  parameter int MAX_KS = 7,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] iw_i,
  input  logic [CNT_W-1:0] ih_i,
  input  logic [CNT_W-1:0] ic_i,
  input  logic [CNT_W-1:0] oc_i,
  input  logic [3:0]       ks_i,
  input  logic [3:0]       stride_i,
  input  logic [3:0]       pad_i,
  output logic             load_input_req_o,
  input  logic             load_input_ack_i,
  output logic             load_weight_req_o,
  input  logic             load_weight_ack_i,
  output logic             flush_req_o,
  input  logic             flush_ack_i,
  output logic             exec_valid_o,
  input  logic             exec_ready_i,
  output logic [CNT_W-1:0] oci_o,
  output logic [CNT_W-1:0] ico_o,
  output logic [CNT_W-1:0] wi_o,
  output logic [CNT_W-1:0] wj_o,
  output logic [CNT_W-1:0] oco_o,
  output logic [CNT_W-1:0] i_o,
  output logic [CNT_W-1:0] j_o,
  output logic             busy_o,
  output logic             end_o,
  output logic             cfg_err_o
);

  localparam int XW    = CNT_W + 3;
  localparam int LOG_W = $clog2(WORD_W);
  localparam int LOG_T = $clog2(TPO);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_IN, S_LOAD_W, S_EXEC, S_FLUSH, S_END} state_t;

  state_t r_state, w_next;

  logic [3:0]              r_stride;
  logic signed [XW-1:0]    r_org, r_i_lim, r_j_lim, r_i, r_j;
  logic [CNT_W-1:0]        r_icw_last, r_oct_last, r_ks_last;
  logic [CNT_W-1:0]        r_oci, r_ico, r_wi, r_wj, r_oco;
  logic                    r_li_req, r_lw_req, r_fl_req, r_exec_valid, r_end, r_cfg_err;

  logic w_cfg_bad, w_fire, w_oci_last, w_ico_last, w_wi_last, w_wj_last, w_tile_done;
  logic w_i_last, w_j_last, w_pos_last, w_oco_last;

  assign w_cfg_bad = (ks_i == 4'd0) || (32'(ks_i) > 32'(MAX_KS)) || (stride_i == 4'd0) ||
                     (ic_i == '0) || (oc_i == '0) ||
                     ((XW'(iw_i) + XW'({pad_i, 1'b0})) < XW'(ks_i)) ||
                     ((XW'(ih_i) + XW'({pad_i, 1'b0})) < XW'(ks_i));

  assign w_fire      = r_exec_valid && exec_ready_i;
  assign w_oci_last  = (r_oci == CNT_W'(TPO - 1));
  assign w_ico_last  = (r_ico == r_icw_last);
  assign w_wi_last   = (r_wi == r_ks_last);
  assign w_wj_last   = (r_wj == r_ks_last);
  assign w_tile_done = w_oci_last && w_ico_last && w_wi_last && w_wj_last;
  // A column/row is last when the next window origin would no longer fit inside the padded map.
  assign w_i_last    = (r_i > r_i_lim);
  assign w_j_last    = (r_j > r_j_lim);
  assign w_pos_last  = w_i_last && w_j_last;
  assign w_oco_last  = (r_oco == r_oct_last);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (start_i) w_next = w_cfg_bad ? S_END : S_LOAD_IN;
      S_LOAD_IN: if (load_input_ack_i) w_next = S_LOAD_W;
      S_LOAD_W:  if (load_weight_ack_i) w_next = S_EXEC;
      S_EXEC:    if (w_fire && w_tile_done) w_next = S_FLUSH;
      S_FLUSH: begin
        if (flush_ack_i) begin
          if (!w_pos_last)     w_next = S_EXEC;
          else if (w_oco_last) w_next = S_END;
          else                 w_next = S_LOAD_W;
        end
      end
      S_END:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_li_req     <= 1'b0;
      r_lw_req     <= 1'b0;
      r_fl_req     <= 1'b0;
      r_exec_valid <= 1'b0;
      r_end        <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_li_req     <= (w_next == S_LOAD_IN);
      r_lw_req     <= (w_next == S_LOAD_W);
      r_fl_req     <= (w_next == S_FLUSH);
      r_exec_valid <= (w_next == S_EXEC);
      r_end        <= (w_next == S_END);
      r_cfg_err    <= (r_state == S_IDLE) && start_i && w_cfg_bad;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stride   <= '0;
      r_org      <= '0;
      r_i_lim    <= '0;
      r_j_lim    <= '0;
      r_icw_last <= '0;
      r_oct_last <= '0;
      r_ks_last  <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_oci      <= '0;
      r_ico      <= '0;
      r_wi       <= '0;
      r_wj       <= '0;
      r_oco      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_stride   <= stride_i;
            r_org      <= XW'(0) - XW'(pad_i);
            r_i_lim    <= XW'(iw_i) + XW'(pad_i) - XW'(ks_i) - XW'(stride_i);
            r_j_lim    <= XW'(ih_i) + XW'(pad_i) - XW'(ks_i) - XW'(stride_i);
            r_icw_last <= (ic_i - CNT_W'(1)) >> LOG_W;
            r_oct_last <= (oc_i - CNT_W'(1)) >> LOG_T;
            r_ks_last  <= CNT_W'(ks_i) - CNT_W'(1);
            r_i        <= XW'(0) - XW'(pad_i);
            r_j        <= XW'(0) - XW'(pad_i);
            r_oci      <= '0;
            r_ico      <= '0;
            r_wi       <= '0;
            r_wj       <= '0;
            r_oco      <= '0;
          end
        end
        S_EXEC: begin
          if (w_fire) begin
            if (!w_oci_last) begin
              r_oci <= r_oci + CNT_W'(1);
            end else begin
              r_oci <= '0;
              if (!w_ico_last) begin
                r_ico <= r_ico + CNT_W'(1);
              end else begin
                r_ico <= '0;
                if (!w_wi_last) begin
                  r_wi <= r_wi + CNT_W'(1);
                end else begin
                  r_wi <= '0;
                  r_wj <= w_wj_last ? '0 : r_wj + CNT_W'(1);
                end
              end
            end
          end
        end
        S_FLUSH: begin
          if (flush_ack_i) begin
            if (w_pos_last) begin
              if (!w_oco_last) r_oco <= r_oco + CNT_W'(1);
              r_i <= r_org;
              r_j <= r_org;
            end else if (w_i_last) begin
              r_i <= r_org;
              r_j <= r_j + XW'(r_stride);
            end else begin
              r_i <= r_i + XW'(r_stride);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign load_input_req_o  = r_li_req;
  assign load_weight_req_o = r_lw_req;
  assign flush_req_o       = r_fl_req;
  assign exec_valid_o      = r_exec_valid;
  assign oci_o             = r_oci;
  assign ico_o             = r_ico;
  assign wi_o              = r_wi;
  assign wj_o              = r_wj;
  assign oco_o             = r_oco;
  assign i_o               = r_i[CNT_W-1:0];
  assign j_o               = r_j[CNT_W-1:0];
  assign busy_o            = (r_state != S_IDLE);
  assign end_o             = r_end;
  assign cfg_err_o         = r_cfg_err;

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// tb/tb_conv_loop_sequencer.sv - self-checking bench for conv_loop_sequencer
module tb_conv_loop_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [15:0] iw_i, ih_i, ic_i, oc_i;
  logic [3:0]  ks_i, stride_i, pad_i;
  logic        load_input_req_o, load_input_ack_i;
  logic        load_weight_req_o, load_weight_ack_i;
  logic        flush_req_o, flush_ack_i;
  logic        exec_valid_o, exec_ready_i;
  logic [15:0] oci_o, ico_o, wi_o, wj_o, oco_o, i_o, j_o;
  logic        busy_o, end_o, cfg_err_o;

  conv_loop_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .iw_i(iw_i), .ih_i(ih_i), .ic_i(ic_i), .oc_i(oc_i),
    .ks_i(ks_i), .stride_i(stride_i), .pad_i(pad_i),
    .load_input_req_o(load_input_req_o), .load_input_ack_i(load_input_ack_i),
    .load_weight_req_o(load_weight_req_o), .load_weight_ack_i(load_weight_ack_i),
    .flush_req_o(flush_req_o), .flush_ack_i(flush_ack_i),
    .exec_valid_o(exec_valid_o), .exec_ready_i(exec_ready_i),
    .oci_o(oci_o), .ico_o(ico_o), .wi_o(wi_o), .wj_o(wj_o), .oco_o(oco_o),
    .i_o(i_o), .j_o(j_o), .busy_o(busy_o), .end_o(end_o), .cfg_err_o(cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int iw, ih, ic, oc, ks, st, pd;
    int e_li, e_lw, e_fl, e_fires, e_err;
    int e_i0, e_j0, e_il, e_jl;
  } vec_t;

  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  int   n_li, n_lw, n_fl, n_end, n_err, n_fires, tile_fires, cur_exp_fires;
  int   first_i, first_j, last_i, last_j, end_cyc, bad;
  int   vis_i[$], vis_j[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_cfg(input vec_t v);
    iw_i = 16'(v.iw); ih_i = 16'(v.ih); ic_i = 16'(v.ic); oc_i = 16'(v.oc);
    ks_i = 4'(v.ks); stride_i = 4'(v.st); pad_i = 4'(v.pd);
  endtask

  // Responds to every request immediately and records what the sequencer did.
  task automatic run_layer(input int lim);
    n_li = 0; n_lw = 0; n_fl = 0; n_end = 0; n_err = 0; n_fires = 0; tile_fires = 0;
    first_i = 0; first_j = 0; last_i = 0; last_j = 0; end_cyc = -1;
    vis_i.delete(); vis_j.delete();
    exec_ready_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < lim; c++) begin
      if (end_o) begin
        n_end++;
        if (end_cyc < 0) end_cyc = c;
      end
      if (cfg_err_o) n_err++;
      if (load_input_req_o) n_li++;
      if (load_weight_req_o) n_lw++;
      load_input_ack_i  = load_input_req_o;
      load_weight_ack_i = load_weight_req_o;
      if (flush_req_o) begin
        n_fl++;
        chk("tile_fires", tile_fires, cur_exp_fires);
        tile_fires = 0;
        last_i = int'($signed(i_o));
        last_j = int'($signed(j_o));
        vis_i.push_back(last_i);
        vis_j.push_back(last_j);
      end
      flush_ack_i = flush_req_o;
      if (exec_valid_o && exec_ready_i) begin
        if (n_fires == 0) begin
          first_i = int'($signed(i_o));
          first_j = int'($signed(j_o));
        end
        n_fires++;
        tile_fires++;
      end
      tick();
      if (end_cyc >= 0 && c >= end_cyc + 3) break;
    end
    load_input_ack_i = 1'b0; load_weight_ack_i = 1'b0; flush_ack_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got 1, want 0");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4, 4, 32, 8, 3, 1, 0,  1, 1, 4, 72, 0,   0,  0, 1, 1};
    vecs[1] = '{4, 4, 32, 8, 3, 1, 1,  1, 1, 16, 72, 0, -1, -1, 2, 2};
    vecs[2] = '{5, 5, 40, 16, 3, 2, 0, 1, 2, 8, 144, 0,  0,  0, 2, 2};
    vecs[3] = '{4, 4, 32, 8, 0, 1, 0,  0, 0, 0, 0, 1,    0,  0, 0, 0};
    vecs[4] = '{4, 4, 32, 8, 9, 1, 0,  0, 0, 0, 0, 1,    0,  0, 0, 0};

    rst_ni = 1'b0; start_i = 1'b0; exec_ready_i = 1'b1;
    load_input_ack_i = 1'b0; load_weight_ack_i = 1'b0; flush_ack_i = 1'b0;
    set_cfg(vecs[0]);
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
    chk("reset_ctrl", int'({load_input_req_o, load_weight_req_o, flush_req_o, exec_valid_o,
                            busy_o, end_o, cfg_err_o}), 0);
    chk("reset_idx", int'(oci_o | ico_o | wi_o | wj_o | oco_o | i_o | j_o), 0);

    for (int v = 0; v < 5; v++) begin
      set_cfg(vecs[v]);
      cur_exp_fires = vecs[v].e_fires;
      run_layer(5000);
      chk($sformatf("v%0d_end_seen", v), int'(end_cyc >= 0), 1);
      chk($sformatf("v%0d_load_in", v), n_li, vecs[v].e_li);
      chk($sformatf("v%0d_load_w", v), n_lw, vecs[v].e_lw);
      chk($sformatf("v%0d_flush", v), n_fl, vecs[v].e_fl);
      chk($sformatf("v%0d_end", v), n_end, 1);
      chk($sformatf("v%0d_cfg_err", v), n_err, vecs[v].e_err);
      chk($sformatf("v%0d_busy_after", v), int'(busy_o), 0);
      if (vecs[v].e_err != 0) begin
        chk($sformatf("v%0d_err_latency", v), end_cyc, 0);
      end else begin
        chk($sformatf("v%0d_fires", v), n_fires, vecs[v].e_fl * vecs[v].e_fires);
        chk($sformatf("v%0d_first_i", v), first_i, vecs[v].e_i0);
        chk($sformatf("v%0d_first_j", v), first_j, vecs[v].e_j0);
        chk($sformatf("v%0d_last_i", v), last_i, vecs[v].e_il);
        chk($sformatf("v%0d_last_j", v), last_j, vecs[v].e_jl);
      end
    end

    // Backpressure on exec, then a stalled flush ack.
    set_cfg(vecs[0]);
    exec_ready_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 20 && !exec_valid_o; c++) begin
      load_input_ack_i  = load_input_req_o;
      load_weight_ack_i = load_weight_req_o;
      tick();
    end
    load_input_ack_i = 1'b0; load_weight_ack_i = 1'b0;
    chk("bp_valid", int'(exec_valid_o), 1);
    repeat (10) tick();
    chk("bp_oci_10", int'(oci_o), 2);
    chk("bp_wi_10", int'(wi_o), 1);
    exec_ready_i = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (oci_o != 16'd2 || wi_o != 16'd1 || !exec_valid_o) bad++;
    end
    chk("bp_frozen", bad, 0);
    exec_ready_i = 1'b1;
    tick();
    chk("bp_resume_oci", int'(oci_o), 3);
    for (int c = 0; c < 200 && !flush_req_o; c++) tick();
    chk("fh_req", int'(flush_req_o), 1);
    chk("fh_idx_clear", int'(oci_o | ico_o | wi_o | wj_o), 0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (!flush_req_o || exec_valid_o) bad++;
      tick();
    end
    chk("fh_hold", bad, 0);
    flush_ack_i = 1'b1;
    tick();
    flush_ack_i = 1'b0;
    chk("fh_release_req", int'(flush_req_o), 0);
    chk("fh_release_valid", int'(exec_valid_o), 1);
    chk("fh_next_i", int'($signed(i_o)), 1);
    chk("fh_next_j", int'($signed(j_o)), 0);

    // Asynchronous reset in the middle of a tile.
    tick(); tick();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_ctrl", int'({load_input_req_o, load_weight_req_o, flush_req_o, exec_valid_o,
                           busy_o, end_o, cfg_err_o}), 0);
    chk("arst_idx", int'(oci_o | ico_o | wi_o | wj_o | oco_o | i_o | j_o), 0);
    tick();
    rst_ni = 1'b1;
    tick();
    cur_exp_fires = 72;
    run_layer(5000);
    chk("rerun_load_in", n_li, 1);
    chk("rerun_flush", n_fl, 4);
    chk("rerun_end", n_end, 1);
    chk("rerun_visits", vis_i.size(), 4);
    if (vis_i.size() == 4) begin
      chk("rerun_pos0", vis_i[0] * 16 + vis_j[0], 0 * 16 + 0);
      chk("rerun_pos1", vis_i[1] * 16 + vis_j[1], 1 * 16 + 0);
      chk("rerun_pos2", vis_i[2] * 16 + vis_j[2], 0 * 16 + 1);
      chk("rerun_pos3", vis_i[3] * 16 + vis_j[3], 1 * 16 + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
